// File: rtl/odd_seq_pkg.sv
// Shared definitions for the odd-number sequence generator/checker pair.
package odd_seq_pkg;

  localparam int unsigned WIDTH_DEF   = 7;
  localparam int unsigned MAX_ODD_DEF = 101;
  localparam int unsigned ERR_W_DEF   = 8;
  localparam int unsigned WRAP_W      = 16;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  // Successor in the odd sequence; wraps to 1 once max_odd is reached.
  function automatic int unsigned next_odd(input int unsigned v, input int unsigned max_odd);
    return (v >= max_odd) ? 32'd1 : (v + 32'd2);
  endfunction

endpackage

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count up on inc, stick at all-ones; reset and clear take priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/odd_seq_checker.sv
// Checks a 1,3,5,...,MAX_ODD,1,... stream; locks on value 1, flags mismatches.
// Optional: define ODD_SEQ_CHECKER_WRAP_STATS_EN to add the wrap_count output.
module odd_seq_checker
  import odd_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned MAX_ODD = MAX_ODD_DEF,
  parameter int unsigned ERR_W   = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
`ifdef ODD_SEQ_CHECKER_WRAP_STATS_EN
  output logic [WRAP_W-1:0] wrap_count,
`endif
  output logic [WIDTH-1:0]  expected
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] w_expected_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  logic             r_in_ready;
  logic             w_in_ready_nxt;
  logic             r_err_pulse;
  logic             w_err_pulse_nxt;
  logic             w_err_inc;
  logic             w_accept;

  assign w_accept = in_valid & r_in_ready;

  // Next-state and next-output decode; everything lands in registers below.
  always_comb begin
    w_state_nxt     = r_state;
    w_expected_nxt  = r_expected;
    w_locked_nxt    = r_locked;
    w_in_ready_nxt  = r_in_ready;
    w_err_pulse_nxt = 1'b0;
    w_err_inc       = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_in_ready_nxt = 1'b1;
        if (w_accept && (in_data == WIDTH'(1))) begin
          w_state_nxt    = ST_LOCKED;
          w_expected_nxt = WIDTH'(next_odd(32'd1, MAX_ODD));
          w_locked_nxt   = 1'b1;
        end
      end
      ST_LOCKED: begin
        w_in_ready_nxt = 1'b1;
        if (w_accept) begin
          if (in_data == r_expected) begin
            w_expected_nxt = WIDTH'(next_odd(32'(r_expected), MAX_ODD));
          end else begin
            w_state_nxt     = ST_ERROR;
            w_expected_nxt  = WIDTH'(1);
            w_locked_nxt    = 1'b0;
            w_in_ready_nxt  = 1'b0;
            w_err_pulse_nxt = 1'b1;
            w_err_inc       = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        // One dead cycle, then resume hunting for the next 1.
        w_state_nxt    = ST_SEARCH;
        w_in_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt    = ST_SEARCH;
        w_expected_nxt = WIDTH'(1);
        w_locked_nxt   = 1'b0;
        w_in_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset holds in_ready low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_SEARCH;
      r_expected  <= WIDTH'(1);
      r_locked    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_locked    <= w_locked_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_err_pulse <= w_err_pulse_nxt;
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .clr   (1'b0),
    .count (err_count)
  );

`ifdef ODD_SEQ_CHECKER_WRAP_STATS_EN
  logic w_wrap_inc;

  // A matching MAX_ODD beat in LOCKED is the wrap point back to 1.
  assign w_wrap_inc = w_accept && (r_state == ST_LOCKED) && (in_data == r_expected)
                      && (32'(r_expected) >= MAX_ODD);

  sat_counter #(
    .WIDTH (WRAP_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_wrap_inc),
    .clr   (1'b0),
    .count (wrap_count)
  );
`endif

  assign in_ready  = r_in_ready;
  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign expected  = r_expected;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Randomised and directed bench for odd_seq_checker against a sequence-index model.
module tb_odd_seq_checker;

  localparam int unsigned WIDTH   = 7;
  localparam int unsigned MAX_ODD = 101;
  localparam int unsigned ERR_W   = 8;
  localparam int          N_ODD   = (MAX_ODD + 1) / 2;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;
`ifdef ODD_SEQ_CHECKER_WRAP_STATS_EN
  logic [15:0]      wrap_count;
`endif

  odd_seq_checker #(
    .WIDTH   (WIDTH),
    .MAX_ODD (MAX_ODD),
    .ERR_W   (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
`ifdef ODD_SEQ_CHECKER_WRAP_STATS_EN
    .wrap_count (wrap_count),
`endif
    .expected   (expected)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: position within the 1,3,...,MAX_ODD cycle while locked.
  bit m_locked = 1'b0;
  int m_pos    = 0;
  bit m_in_err = 1'b0;
  bit m_ready  = 1'b0;
  bit m_pulse  = 1'b0;
  int m_errs   = 0;
  int m_wraps  = 0;

  function automatic int m_expected();
    return m_locked ? (2 * ((m_pos + 1) % N_ODD) + 1) : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int d);
    bit acc;
    acc = v && m_ready;
    if (!r) begin
      m_locked = 1'b0; m_pos = 0; m_in_err = 1'b0; m_ready = 1'b0;
      m_pulse = 1'b0; m_errs = 0; m_wraps = 0;
    end else if (m_in_err) begin
      m_in_err = 1'b0; m_ready = 1'b1; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      m_ready = 1'b1;
      if (acc) begin
        if (!m_locked) begin
          if (d == 1) begin
            m_locked = 1'b1;
            m_pos    = 0;
          end
        end else if (d == m_expected()) begin
          if (d == MAX_ODD && m_wraps < 65535) m_wraps++;
          m_pos = (m_pos + 1) % N_ODD;
        end else begin
          m_locked = 1'b0; m_in_err = 1'b1; m_ready = 1'b0; m_pulse = 1'b1;
          if (m_errs < ERR_MAX) m_errs++;
        end
      end
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare 1 time unit later.
  task automatic step(input bit r, input bit v, input int d);
    rst      = r;
    in_valid = v;
    in_data  = WIDTH'(d);
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check_eq("in_ready",  32'(in_ready),  32'(m_ready));
    check_eq("locked",    32'(locked),    32'(m_locked));
    check_eq("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check_eq("err_count", 32'(err_count), 32'(m_errs));
    check_eq("expected",  32'(expected),  32'(m_expected()));
`ifdef ODD_SEQ_CHECKER_WRAP_STATS_EN
    check_eq("wrap_count", 32'(wrap_count), 32'(m_wraps));
`endif
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    step(0, 0, 0);
    step(0, 1, 1);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_exp",   32'(expected), 32'd1);
    step(1, 0, 0);
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);

    // Lock on 1, then 3, 5.
    step(1, 1, 1);
    check_eq("lock_after_1", 32'(locked), 32'd1);
    step(1, 1, 3);
    step(1, 1, 5);
    check_eq("seq_exp7", 32'(expected), 32'd7);
    check_eq("seq_err0", 32'(err_count), 32'd0);

    // Run through the wrap: ... 97, 99, 101, 1, 3.
    for (int v = 7; v <= MAX_ODD; v += 2) step(1, 1, v);
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 3);
    check_eq("wrap_exp5", 32'(expected), 32'd5);
    check_eq("wrap_noerr", 32'(err_count), 32'd0);
`ifdef ODD_SEQ_CHECKER_WRAP_STATS_EN
    check_eq("wrap_cnt1", 32'(wrap_count), 32'd1);
`endif

    // Mismatch at expected=11.
    step(1, 1, 5); step(1, 1, 7); step(1, 1, 9);
    check_eq("pre_err_exp11", 32'(expected), 32'd11);
    step(1, 1, 12);
    check_eq("err_pulse_hi", 32'(err_pulse), 32'd1);
    check_eq("err_cnt1",     32'(err_count), 32'd1);
    check_eq("err_ready0",   32'(in_ready),  32'd0);
    check_eq("err_unlock",   32'(locked),    32'd0);
    step(1, 1, 1);  // offered during ERROR, must be ignored
    check_eq("err_pulse_lo", 32'(err_pulse), 32'd0);
    check_eq("search_ready", 32'(in_ready),  32'd1);
    check_eq("no_lock_in_err", 32'(locked),  32'd0);

    // SEARCH ignores non-1 values.
    step(1, 1, 7); step(1, 1, 9);
    check_eq("search_nolock", 32'(locked), 32'd0);
    step(1, 1, 1);
    check_eq("relock", 32'(locked), 32'd1);
    check_eq("relock_exp3", 32'(expected), 32'd3);
    check_eq("relock_err1", 32'(err_count), 32'd1);

    // Hold with no valid: nothing moves.
    for (int i = 0; i < 5; i++) step(1, 0, 4);
    check_eq("idle_hold_exp", 32'(expected), 32'd3);

    // Advance to expected=41, then reset with a valid beat present.
    for (int v = 3; v <= 39; v += 2) step(1, 1, v);
    check_eq("pre_rst_exp41", 32'(expected), 32'd41);
    step(0, 1, 41);
    check_eq("midrst_exp", 32'(expected), 32'd1);
    check_eq("midrst_err", 32'(err_count), 32'd0);
    check_eq("midrst_pulse", 32'(err_pulse), 32'd0);
    check_eq("midrst_lock", 32'(locked), 32'd0);
    step(1, 0, 0);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1);
      step(1, 1, (i % 2 == 0) ? 0 : 102);
      step(1, 0, 0);
    end
    check_eq("sat_255", 32'(err_count), 32'd255);
    step(1, 1, 1); step(1, 1, 8); step(1, 0, 0);
    check_eq("sat_hold", 32'(err_count), 32'd255);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit v;
      int d;
      r = ($urandom_range(0, 499) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 39) != 0) ? m_expected() : int'($urandom_range(0, 127));
      step(r, v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/odd_seq_checker.md
ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

Interface
REQ-001 Parameter: WIDTH, 7, data width of the checked stream.
REQ-002 Parameter: MAX_ODD, 101, last odd value before the sequence wraps to 1.
REQ-003 Parameter: ERR_W, 8, width of the saturating error counter.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  reset, synchronous, active-low.
REQ-006 Port: in_valid  input  1  upstream beat valid.
REQ-007 Port: in_data  input  WIDTH  beat value from the odd-sequence generator.
REQ-008 Port: in_ready  output  1  checker can accept a beat.
REQ-009 Port: locked  output  1  checker is synchronised to the sequence.
REQ-010 Port: err_pulse  output  1  one-cycle flag for a sequence mismatch.
REQ-011 Port: err_count  output  ERR_W  saturating mismatch count.
REQ-012 Port: expected  output  WIDTH  next value the checker requires.

Function
REQ-013 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1; no other cycle SHALL change state or outputs, except for reset and the ERROR exit.
REQ-014 The legal sequence SHALL be 1, 3, 5, ..., MAX_ODD, 1, 3, ...; next(v) = 1 if v >= MAX_ODD, else v+2, computed in WIDTH bits.
REQ-015 FSM states: SEARCH, LOCKED, ERROR (enum).
REQ-016 SEARCH: in_ready=1; an accepted beat with value 1 -> LOCKED with expected=3; any other accepted value stays in SEARCH with no error.
REQ-017 LOCKED: in_ready=1; an accepted beat equal to expected -> stay in LOCKED with expected=next(expected).
REQ-018 LOCKED: an accepted beat not equal to expected (including even values, 0, and values > MAX_ODD) -> ERROR.
REQ-019 On the LOCKED->ERROR transition: err_pulse=1 in the following cycle only; err_count increments by 1 and saturates at all-ones.
REQ-020 ERROR: in_ready=0 for exactly one cycle, expected=1, locked=0; the next state is unconditionally SEARCH.
REQ-021 The LOCKED state with no accepted beat SHALL hold expected and locked unchanged, with no timeout.
REQ-022 locked = (state == LOCKED), registered, with no combinational path from in_data.
REQ-023 All outputs SHALL be registered, and their latency from the accepted beat edge SHALL be one edge.

Reset
REQ-024 rst=0 at a rising edge: state=SEARCH, expected=1, locked=0, err_pulse=0, err_count=0, in_ready=0 during reset; in_ready=1 on the first cycle after release.
REQ-025 Reset asserted mid-sequence or in ERROR SHALL override all transitions, discard any beat on that edge, and count no error.

Configuration
REQ-026 Macro ODD_SEQ_CHECKER_WRAP_STATS_EN defined: add output wrap_count (16 bits, saturating), which increments on each accepted MAX_ODD->1 transition in LOCKED and is cleared by reset.
REQ-027 Macro ODD_SEQ_CHECKER_WRAP_STATS_EN undefined: no wrap_count port and no wrap logic; all other behaviour is identical.

Structure
REQ-028 Package odd_seq_pkg SHALL hold the FSM state enum, WIDTH/MAX_ODD defaults, and a next_odd() function shared with the generator side.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter (parameter width, inc, clr), used for err_count and wrap_count.
REQ-030 The remaining logic SHALL be one FSM with a next-state process and a register process, totalling 120-400 RTL lines.

Verification
REQ-031 Reset, then beats 1,3,5 -> locked=1 after the beat of value 1; expected=7; err_count=0.
REQ-032 Locked, send 97,99,101,1,3 -> no err_pulse; expected=5; wrap_count=1 with the macro defined.
REQ-033 Locked at expected=11, send 12 -> err_pulse high for 1 cycle; err_count=1; next cycle in_ready=0, locked=0; then SEARCH with in_ready=1.
REQ-034 In SEARCH, send 7,9,1 -> no error; locked=1 after the value 1; expected=3.
REQ-035 Force 300 mismatches with ERR_W=8 -> err_count=255 and holds at 255.
REQ-036 Locked at expected=41 with in_valid held high, assert rst for one cycle -> state=SEARCH, expected=1, err_count=0, no err_pulse.
